// File: rtl/clk_divider_multi_if.sv
// Configuration/status bundle for clk_divider_multi.
// sync_in exists only when CLKDIV_SYNC_EN is defined.
interface clk_divider_multi_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int CH_BITS  = 2
);
  logic [CHANNELS-1:0] enable;
  logic                wr_en;
  logic [CH_BITS-1:0]  wr_ch;
  logic [WIDTH-1:0]    wr_period;
  logic [WIDTH-1:0]    wr_high;
  logic                wr_oneshot;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] done;
  logic [CHANNELS-1:0] pending;
`ifdef CLKDIV_SYNC_EN
  logic                sync_in;
`endif

  modport master (
`ifdef CLKDIV_SYNC_EN
    output sync_in,
`endif
    output enable, wr_en, wr_ch, wr_period, wr_high, wr_oneshot,
    input  out, done, pending
  );

  modport slave (
`ifdef CLKDIV_SYNC_EN
    input  sync_in,
`endif
    input  enable, wr_en, wr_ch, wr_period, wr_high, wr_oneshot,
    output out, done, pending
  );
endinterface

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable divider / pulse generator with shadowed config.
// Optional CLKDIV_SYNC_EN adds bus.sync_in to phase-align all running channels.
module clk_divider_multi #(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 16,
  parameter int DEFAULT_PERIOD = 10,
  parameter int DEFAULT_HIGH   = 1,
  parameter int CH_BITS        = 2
) (
  input  logic              clk,
  input  logic              rst,
  clk_divider_multi_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // cnt + H >= P in WIDTH+1 bits is the same test as cnt >= P-H, without a negative term when H > P
  function automatic logic f_high(input logic [WIDTH-1:0] c,
                                  input logic [WIDTH-1:0] p,
                                  input logic [WIDTH-1:0] h);
    return ({1'b0, c} + {1'b0, h}) >= {1'b0, p};
  endfunction

  logic [CHANNELS-1:0] w_out_v, w_done_v, w_pend_v;
  logic                w_sync;

`ifdef CLKDIV_SYNC_EN
  assign w_sync = bus.sync_in;
`else
  assign w_sync = 1'b0;
`endif

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_cnt, w_cnt, r_p, w_p, r_h, w_h, r_sp, w_sp, r_sh, w_sh;
    logic [WIDTH-1:0] w_ep, w_eh;
    logic             r_m, w_m, r_sm, w_sm, w_em;
    logic             r_out, w_out, r_done, w_done, r_pend, w_pend;
    logic             w_wr, w_apply, w_last;

    assign w_wr   = bus.wr_en && (bus.wr_ch == CH_BITS'(gi));
    // Values the channel runs with if the shadow is applied on this edge
    assign w_ep   = r_pend ? r_sp : r_p;
    assign w_eh   = r_pend ? r_sh : r_h;
    assign w_em   = r_pend ? r_sm : r_m;
    assign w_last = ({1'b0, r_cnt} + (WIDTH+1)'(1)) == {1'b0, r_p};

    always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_out   = 1'b0;
      w_done  = 1'b0;
      w_apply = 1'b0;
      case (r_state)
        IDLE: begin
          w_apply = 1'b1;
          w_cnt   = '0;
          if (bus.enable[gi] && (w_ep != '0)) begin
            w_state = RUN;
            w_out   = f_high('0, w_ep, w_eh);
          end
        end
        RUN: begin
          if (!bus.enable[gi]) begin
            w_state = IDLE;
            w_cnt   = '0;
            w_apply = 1'b1;
          end else if (w_sync || w_last) begin
            w_apply = 1'b1;
            w_cnt   = '0;
            if (!w_sync && r_m) begin
              w_state = DONE;
              w_done  = 1'b1;
            end else if (w_ep == '0) begin
              w_state = IDLE;
            end else begin
              w_out = f_high('0, w_ep, w_eh);
            end
          end else begin
            w_cnt = r_cnt + WIDTH'(1);
            w_out = f_high(w_cnt, r_p, r_h);
          end
        end
        DONE: begin
          w_cnt = '0;
          if (!bus.enable[gi]) begin
            w_state = IDLE;
            w_apply = 1'b1;
          end
        end
        default: w_state = IDLE;
      endcase

      w_p = w_apply ? w_ep : r_p;
      w_h = w_apply ? w_eh : r_h;
      w_m = w_apply ? w_em : r_m;
      // A write on an apply edge refills the shadow and keeps pending for the next boundary
      w_pend = w_wr ? 1'b1 : (w_apply ? 1'b0 : r_pend);
      w_sp   = w_wr ? bus.wr_period  : r_sp;
      w_sh   = w_wr ? bus.wr_high    : r_sh;
      w_sm   = w_wr ? bus.wr_oneshot : r_sm;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_out   <= 1'b0;
        r_done  <= 1'b0;
        r_pend  <= 1'b0;
        r_p     <= WIDTH'(DEFAULT_PERIOD);
        r_h     <= WIDTH'(DEFAULT_HIGH);
        r_m     <= 1'b0;
        r_sp    <= WIDTH'(DEFAULT_PERIOD);
        r_sh    <= WIDTH'(DEFAULT_HIGH);
        r_sm    <= 1'b0;
      end else begin
        r_state <= w_state;
        r_cnt   <= w_cnt;
        r_out   <= w_out;
        r_done  <= w_done;
        r_pend  <= w_pend;
        r_p     <= w_p;
        r_h     <= w_h;
        r_m     <= w_m;
        r_sp    <= w_sp;
        r_sh    <= w_sh;
        r_sm    <= w_sm;
      end
    end

    assign w_out_v[gi]  = r_out;
    assign w_done_v[gi] = r_done;
    assign w_pend_v[gi] = r_pend;
  end

  assign bus.out     = w_out_v;
  assign bus.done    = w_done_v;
  assign bus.pending = w_pend_v;

endmodule

// File: tb/tb_clk_divider_multi.sv
// Scoreboard bench for clk_divider_multi: per-cycle expected out/done/pending
// vectors are queued with the stimulus and compared one cycle at a time.
module tb_clk_divider_multi;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clk_divider_multi_if #(.CHANNELS(4), .WIDTH(16), .CH_BITS(3)) bus ();

  clk_divider_multi #(
    .CHANNELS(4), .WIDTH(16), .DEFAULT_PERIOD(10), .DEFAULT_HIGH(1), .CH_BITS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] e_out;
    logic [3:0] e_done;
    logic [3:0] e_pend;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected output level for counter value c: high in the last h cycles of p
  function automatic logic f_out(input int c, input int p, input int h);
    return (c + h) >= p;
  endfunction

  task automatic push(input string tag, input logic [3:0] eo, input logic [3:0] ed,
                      input logic [3:0] ep);
    exp_t e;
    e.tag = tag; e.e_out = eo; e.e_done = ed; e.e_pend = ep;
    sb.push_back(e);
  endtask

  // Stimulus steps run 2 time units after the edge; the monitor samples at 1
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic write_cycle(input logic [2:0] ch, input int p, input int h,
                             input logic m, input logic [3:0] ep);
    bus.wr_en      = 1'b1;
    bus.wr_ch      = ch;
    bus.wr_period  = 16'(p);
    bus.wr_high    = 16'(h);
    bus.wr_oneshot = m;
    push("write", 4'h0, 4'h0, ep);
    tick(1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq({e.tag, "_out"},  32'(bus.out),     32'(e.e_out));
        check_eq({e.tag, "_done"}, 32'(bus.done),    32'(e.e_done));
        check_eq({e.tag, "_pend"}, 32'(bus.pending), 32'(e.e_pend));
      end
    end
  end

  initial begin : stim
    logic o, o1;
    int   c0, c1;
    bus.enable = '0; bus.wr_en = 1'b0; bus.wr_ch = '0;
    bus.wr_period = '0; bus.wr_high = '0; bus.wr_oneshot = 1'b0;
`ifdef CLKDIV_SYNC_EN
    bus.sync_in = 1'b0;
`endif
    tick(3);
    rst = 1'b0;
    push("reset", 4'h0, 4'h0, 4'h0);
    tick(1);

    // Defaults on ch0 and ch1: 9 low, 1 high, period 10
    bus.enable = 4'b0011;
    for (int j = 0; j < 25; j++) begin
      o = f_out(j % 10, 10, 1);
      push("default", {2'b00, o, o}, 4'h0, 4'h0);
    end
    tick(25);

    // Reprogram ch1 mid-period; takes effect at its next boundary
    bus.wr_en = 1'b1; bus.wr_ch = 3'd1; bus.wr_period = 16'd6;
    bus.wr_high = 16'd3; bus.wr_oneshot = 1'b0;
    o = f_out(5, 10, 1);
    push("wr_ch1", {2'b00, o, o}, 4'h0, 4'b0010);
    tick(1);
    bus.wr_en = 1'b0;
    for (int j = 26; j < 30; j++) begin
      o = f_out(j % 10, 10, 1);
      push("pending", {2'b00, o, o}, 4'h0, 4'b0010);
    end
    for (int j = 30; j < 48; j++) begin
      o  = f_out(j % 10, 10, 1);
      o1 = f_out((j - 30) % 6, 6, 3);
      push("new_p6", {2'b00, o1, o}, 4'h0, 4'h0);
    end
    tick(22);
    bus.enable = 4'b0000;
    push("disable", 4'h0, 4'h0, 4'h0);
    tick(1);

    // One-shot on ch2, run twice via enable re-arm
    write_cycle(3'd2, 4, 2, 1'b1, 4'b0100);
    bus.wr_en = 1'b0;
    push("os_apply", 4'h0, 4'h0, 4'h0);
    tick(1);
    for (int r = 0; r < 2; r++) begin
      bus.enable = 4'b0100;
      for (int j = 0; j < 4; j++) push("oneshot", {1'b0, f_out(j, 4, 2), 2'b00}, 4'h0, 4'h0);
      push("os_done", 4'h0, 4'b0100, 4'h0);
      for (int j = 0; j < 3; j++) push("os_hold", 4'h0, 4'h0, 4'h0);
      tick(8);
      bus.enable = 4'b0000;
      push("os_rearm", 4'h0, 4'h0, 4'h0);
      tick(1);
    end

    // Boundaries: H=0, H>P, P=0, out-of-range channel (5 would alias ch1 if truncated)
    write_cycle(3'd0, 5, 0, 1'b0, 4'b0001);
    write_cycle(3'd1, 8, 12, 1'b0, 4'b0010);
    write_cycle(3'd3, 0, 1, 1'b0, 4'b1000);
    write_cycle(3'd5, 3, 1, 1'b0, 4'b0000);
    bus.wr_en = 1'b0;
    bus.enable = 4'b1011;
    for (int j = 0; j < 12; j++) push("bounds", 4'b0010, 4'h0, 4'h0);
    tick(12);
    bus.enable = 4'b0000;
    push("bounds_off", 4'h0, 4'h0, 4'h0);
    tick(1);

    // Enable dropped during the high phase, then restart from cnt 0
    write_cycle(3'd3, 8, 4, 1'b0, 4'b1000);
    bus.wr_en = 1'b0;
    push("ch3_apply", 4'h0, 4'h0, 4'h0);
    tick(1);
    bus.enable = 4'b1000;
    for (int j = 0; j < 6; j++) push("ch3_run", {f_out(j, 8, 4), 3'b000}, 4'h0, 4'h0);
    tick(6);
    bus.enable = 4'b0000;
    push("ch3_drop", 4'h0, 4'h0, 4'h0);
    tick(1);
    bus.enable = 4'b1000;
    for (int j = 0; j < 8; j++) push("ch3_restart", {f_out(j, 8, 4), 3'b000}, 4'h0, 4'h0);
    tick(8);

    // Asynchronous reset while ch3 is high, then defaults restored
    rst = 1'b1;
    bus.enable = 4'b0000;
    #1;
    check_eq("rst_async_out", 32'(bus.out), 32'h0);
    tick(2);
    rst = 1'b0;
    bus.enable = 4'b1000;
    for (int j = 0; j < 12; j++) push("post_rst", {f_out(j % 10, 10, 1), 3'b000}, 4'h0, 4'h0);
    tick(12);
    bus.enable = 4'b0000;
    push("post_rst_off", 4'h0, 4'h0, 4'h0);
    tick(1);

`ifdef CLKDIV_SYNC_EN
    // ch0 P=10, ch1 P=5 started out of phase, then realigned by sync_in
    write_cycle(3'd1, 5, 1, 1'b0, 4'b0010);
    bus.wr_en = 1'b0;
    push("sync_apply", 4'h0, 4'h0, 4'h0);
    tick(1);
    bus.enable = 4'b0001;
    c0 = 0;
    for (int j = 0; j < 3; j++) begin
      push("sync_pre0", {3'b000, f_out(c0, 10, 1)}, 4'h0, 4'h0);
      c0 = (c0 + 1) % 10;
    end
    tick(3);
    bus.enable = 4'b0011;
    c1 = 0;
    for (int j = 0; j < 4; j++) begin
      push("sync_pre1", {2'b00, f_out(c1, 5, 1), f_out(c0, 10, 1)}, 4'h0, 4'h0);
      c0 = (c0 + 1) % 10;
      c1 = (c1 + 1) % 5;
    end
    tick(4);
    bus.sync_in = 1'b1;
    push("sync_edge", {2'b00, f_out(0, 5, 1), f_out(0, 10, 1)}, 4'h0, 4'h0);
    tick(1);
    bus.sync_in = 1'b0;
    c0 = 1; c1 = 1;
    for (int j = 0; j < 20; j++) begin
      push("sync_post", {2'b00, f_out(c1, 5, 1), f_out(c0, 10, 1)}, 4'h0, 4'h0);
      c0 = (c0 + 1) % 10;
      c1 = (c1 + 1) % 5;
    end
    tick(20);
`else
    c0 = 0; c1 = 0;
    o1 = 1'b0;
    if (c0 != c1 || o1) tick(1);
`endif

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
